// File: rtl/seed_stream_ctrl.sv
// seed_stream_ctrl: valid/ready block sequencer for the SEED round engine.
// Accepts one block per handshake, issues one eng_load pulse, then ROUNDS
// eng_step pulses spaced CLK_DIV cycles apart, and captures eng_dout into a
// single-entry output buffer.
// Optional CBC chaining is built when the macro SEED_CBC_EN is defined;
// the default build is plain ECB and ignores iv / iv_load.
module seed_stream_ctrl #(
  parameter int BLOCK_W = 128,
  parameter int ROUNDS  = 16,
  parameter int CLK_DIV = 1,
  parameter int RND_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
  input  logic               in_dec,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               iv_load,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
  output logic               eng_load,
  output logic [BLOCK_W-1:0] eng_din,
  output logic [BLOCK_W-1:0] eng_key,
  output logic               eng_dec,
  output logic               eng_step,
  output logic [RND_W-1:0]   eng_round,
  input  logic [BLOCK_W-1:0] eng_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_CAPT = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  localparam logic [7:0]       DIV_MAX  = 8'(CLK_DIV);
  localparam logic [7:0]       DIV_ONE  = 8'd1;
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);
  localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);
  localparam logic [RND_W-1:0] RND_ZERO = RND_W'(0);
  localparam logic [BLOCK_W-1:0] BLK_ZERO = BLOCK_W'(0);

  state_t               state_r;
  logic [7:0]           div_r;
  logic [RND_W-1:0]     round_r;
  logic                 eng_load_r;
  logic                 eng_step_r;
  logic [BLOCK_W-1:0]   eng_din_r;
  logic [BLOCK_W-1:0]   eng_key_r;
  logic                 eng_dec_r;
  logic                 out_valid_r;
  logic [BLOCK_W-1:0]   out_data_r;

  logic                 buf_free_s;
  logic                 drain_s;
  logic [BLOCK_W-1:0]   din_s;
  logic [BLOCK_W-1:0]   res_s;

`ifdef SEED_CBC_EN
  logic [BLOCK_W-1:0]   chain_r;
  logic [BLOCK_W-1:0]   chain_eff_s;
  logic [BLOCK_W-1:0]   chain_next_s;

  // CBC data path: an iv_load on the accept edge is seen by the XOR; decrypt
  // chains the ciphertext, which is exactly what eng_din_r holds.
  always_comb begin
    chain_eff_s  = iv_load ? iv : chain_r;
    din_s        = in_dec ? in_data : (in_data ^ chain_eff_s);
    res_s        = eng_dec_r ? (eng_dout ^ chain_r) : eng_dout;
    chain_next_s = eng_dec_r ? eng_din_r : eng_dout;
  end
`else
  logic                 ecb_unused_s;

  // ECB data path: blocks pass straight through; iv/iv_load are not used.
  always_comb begin
    din_s        = in_data;
    res_s        = eng_dout;
    ecb_unused_s = ^{iv, iv_load};
  end
`endif

  // Output buffer status: a drain this cycle frees the slot for a capture.
  always_comb begin
    drain_s    = out_valid_r && out_ready;
    buf_free_s = (!out_valid_r) || out_ready;
  end

  // Sequencer FSM with all engine and output-buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      div_r       <= 8'd0;
      round_r     <= RND_ZERO;
      eng_load_r  <= 1'b0;
      eng_step_r  <= 1'b0;
      eng_din_r   <= BLK_ZERO;
      eng_key_r   <= BLK_ZERO;
      eng_dec_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= BLK_ZERO;
`ifdef SEED_CBC_EN
      chain_r     <= BLK_ZERO;
`endif
    end else begin
      eng_load_r <= 1'b0;
      if (drain_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      case (state_r)
        S_IDLE: begin
`ifdef SEED_CBC_EN
          if (iv_load) begin
            chain_r <= iv;
          end else begin
            chain_r <= chain_r;
          end
`endif
          if (in_valid) begin
            eng_din_r  <= din_s;
            eng_key_r  <= in_key;
            eng_dec_r  <= in_dec;
            eng_load_r <= 1'b1;
            div_r      <= 8'd0;
            state_r    <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          // First RUN cycle already counts as divider value 1.
          div_r      <= DIV_ONE;
          eng_step_r <= (DIV_MAX == DIV_ONE);
          state_r    <= S_RUN;
        end
        S_RUN: begin
          if (div_r == DIV_MAX) begin
            div_r <= DIV_ONE;
            if (round_r == RND_LAST) begin
              round_r    <= RND_ZERO;
              eng_step_r <= 1'b0;
              state_r    <= S_CAPT;
            end else begin
              round_r    <= round_r + RND_ONE;
              eng_step_r <= (DIV_MAX == DIV_ONE);
            end
          end else begin
            div_r      <= div_r + DIV_ONE;
            eng_step_r <= ((div_r + DIV_ONE) == DIV_MAX);
          end
        end
        S_CAPT, S_HOLD: begin
          if (buf_free_s) begin
            out_data_r  <= res_s;
            out_valid_r <= 1'b1;
`ifdef SEED_CBC_EN
            chain_r     <= chain_next_s;
`endif
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == S_IDLE) && !reset;
  assign busy      = (state_r != S_IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign eng_load  = eng_load_r;
  assign eng_din   = eng_din_r;
  assign eng_key   = eng_key_r;
  assign eng_dec   = eng_dec_r;
  assign eng_step  = eng_step_r;
  assign eng_round = round_r;

endmodule
